// File: rtl/tdc_readout_seq.sv
// -----------------------------------------------------------------------------
// tdc_readout_seq
//   Readout sequencer for the TDC status/result frame. Walks a one-hot byte
//   select across the NSEL frame bytes, holds each select for SETTLE cycles,
//   samples the shared readout bus and streams the byte to the host TX path
//   over a valid/ready handshake.
//
//   Optional feature (macro TDC_RDOUT_CHKSUM_EN): an 8-bit running XOR of the
//   NSEL transferred bytes is appended as one extra byte (CHK state).
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        frame request, sampled only in IDLE
//   data_in_i      readout bus, holds the byte addressed by sel_out_o
//   sel_out_o      one-hot byte select (all-zero outside SELECT)
//   tx_data_o      byte to the host path
//   tx_valid_o     tx_data_o is valid
//   tx_ready_i     sink accepts; transfer when tx_valid_o & tx_ready_i
//   busy_o         frame in progress
//   frame_done_o   one-cycle pulse at end of frame
//   byte_idx_o     index of the current byte, 0..NSEL-1
// -----------------------------------------------------------------------------
module tdc_readout_seq #(
  parameter int unsigned NSEL   = 24,
  parameter int unsigned SETTLE = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [7:0]      data_in_i,
  output logic [NSEL-1:0] sel_out_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic [4:0]      byte_idx_o
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSEL - 1);

`ifdef TDC_RDOUT_CHKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SEND   = 3'd2,
    ST_CHK    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SEND   = 3'd2,
    ST_DONE   = 3'd4
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [NSEL-1:0]   sel_q, sel_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xfer_c;
`ifdef TDC_RDOUT_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  // A transfer can only happen while we present valid (SEND or CHK).
  assign xfer_c = tx_valid_q & tx_ready_i;

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
`ifdef TDC_RDOUT_CHKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
`ifdef TDC_RDOUT_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Next-state logic; registered outputs are derived from the next state so
  // they line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
`ifdef TDC_RDOUT_CHKSUM_EN
    chk_d     = chk_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SELECT;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef TDC_RDOUT_CHKSUM_EN
          chk_d   = 8'h00;
`endif
        end
      end

      ST_SELECT: begin
        // Sample the bus on the last settle cycle, while the select is still held.
        if (cnt_q == CNT_LAST) begin
          tx_data_d = data_in_i;
          cnt_d     = '0;
          state_d   = ST_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SEND: begin
        if (xfer_c) begin
`ifdef TDC_RDOUT_CHKSUM_EN
          chk_d = chk_q ^ tx_data_q;
`endif
          if (idx_q == IDX_LAST) begin
`ifdef TDC_RDOUT_CHKSUM_EN
            tx_data_d = chk_q ^ tx_data_q;
            state_d   = ST_CHK;
`else
            state_d   = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SELECT;
          end
        end
      end

`ifdef TDC_RDOUT_CHKSUM_EN
      ST_CHK: begin
        if (xfer_c) begin
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sel_d      = (state_d == ST_SELECT) ? (NSEL'(1) << idx_d) : '0;
`ifdef TDC_RDOUT_CHKSUM_EN
    tx_valid_d = (state_d == ST_SEND) || (state_d == ST_CHK);
`else
    tx_valid_d = (state_d == ST_SEND);
`endif
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  assign sel_out_o    = sel_q;
  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign byte_idx_o   = idx_q;

endmodule

// File: tb/tb_tdc_readout_seq.sv
// -----------------------------------------------------------------------------
// tb_tdc_readout_seq
//   Directed bench for tdc_readout_seq: nominal frame, select legality,
//   backpressure, ignored mid-frame start, mid-frame reset and (with
//   TDC_RDOUT_CHKSUM_EN) the appended checksum byte.
// -----------------------------------------------------------------------------
module tb_tdc_readout_seq;

  localparam int unsigned NSEL   = 24;
  localparam int unsigned SETTLE = 2;
`ifdef TDC_RDOUT_CHKSUM_EN
  localparam int unsigned NBYTES   = NSEL + 1;
  localparam int unsigned DONE_REL = 74;
`else
  localparam int unsigned NBYTES   = NSEL;
  localparam int unsigned DONE_REL = 73;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [7:0]      data_in;
  logic [NSEL-1:0] sel_out;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic            frame_done;
  logic [4:0]      byte_idx;
  logic            dmode;

  always #5 clk = ~clk;

  tdc_readout_seq #(.NSEL(NSEL), .SETTLE(SETTLE)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .data_in_i    (data_in),
    .sel_out_o    (sel_out),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .byte_idx_o   (byte_idx)
  );

  // Readout bus model: byte k of the frame.
  assign data_in = dmode ? ((byte_idx == 5'd23) ? 8'hA5 :
                            (byte_idx == 5'd5)  ? 8'h3C : 8'h00)
                         : 8'h10 + 8'(byte_idx);

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          base_cyc = 0;
  int          first_valid_rel = -1;
  int          done_rel = -1;
  int          done_cnt = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NSEL-1:0] onehot(input logic [4:0] k);
    onehot = '0;
    if (32'(k) < NSEL) onehot[k] = 1'b1;
  endfunction

  // Per-cycle monitor: select legality, transfer capture, frame_done timing.
  always @(negedge clk) begin
    if (mon_en) begin
      check("sel_onehot0", 32'($countones(sel_out) <= 1), 32'd1);
      if (sel_out != '0) check("sel_matches_idx", 32'(sel_out), 32'(onehot(byte_idx)));
      if (tx_valid) check("sel_zero_in_send", 32'(sel_out), 32'd0);
      if (tx_valid && first_valid_rel < 0) first_valid_rel = cyc - base_cyc;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (frame_done) begin
        done_cnt++;
        done_rel = cyc - base_cyc;
      end
    end
  end

  // Called at a falling edge; the following rising edge is cycle 0.
  task automatic pulse_start();
    rx_q.delete();
    first_valid_rel = -1;
    done_rel = -1;
    base_cyc = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", 32'(done_cnt >= target), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_count"}, 32'(rx_q.size()), NBYTES);
    for (int i = 0; i < int'(NSEL); i++) begin
      if (i < rx_q.size()) check({tag, "_byte"}, 32'(rx_q[i]), 32'(8'h10 + 8'(i)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   32'(sel_out),    32'd0);
    check({tag, "_valid"}, 32'(tx_valid),   32'd0);
    check({tag, "_data"},  32'(tx_data),    32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(frame_done), 32'd0);
    check({tag, "_idx"},   32'(byte_idx),   32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    tx_ready = 1'b1;
    dmode = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Nominal frame with tx_ready held high.
    pulse_start();
    check("f1_sel_cycle1", 32'(sel_out), 32'd1);
    check("f1_busy_cycle1", 32'(busy), 32'd1);
    wait_done(1, 200);
    check_frame("f1");
`ifdef TDC_RDOUT_CHKSUM_EN
    if (rx_q.size() > NSEL) check("f1_chksum", 32'(rx_q[NSEL]), 32'h00);
`endif
    check("f1_first_valid", 32'(first_valid_rel), 32'd3);
    check("f1_done_cycle", 32'(done_rel), DONE_REL);
    check("f1_idle_busy", 32'(busy), 32'd0);
    check("f1_idle_idx", 32'(byte_idx), 32'd23);
    check("f1_done_pulse", 32'(frame_done), 32'd0);

    // Backpressure on byte 7, then a start pulse at byte 10 that must be ignored.
    pulse_start();
    n = 0;
    while (!sel_out[7] && n < 100) begin @(negedge clk); n++; end
    check("bp_sel7_seen", 32'(sel_out[7]), 32'd1);
    @(posedge clk); #2 tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_data", 32'(tx_data), 32'h17);
      check("bp_idx", 32'(byte_idx), 32'd7);
      check("bp_sel", 32'(sel_out), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #2 tx_ready = 1'b1;
    n = 0;
    while (byte_idx != 5'd10 && n < 100) begin @(negedge clk); n++; end
    check("ign_idx10_seen", 32'(byte_idx), 32'd10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, 300);
    repeat (5) @(negedge clk);
    check("ign_done_count", 32'(done_cnt), 32'd2);
    check("ign_no_restart", 32'(busy), 32'd0);
    check_frame("bp");

    // Reset during SEND of byte 12, then a fresh frame from byte 0.
    pulse_start();
    n = 0;
    while (!(byte_idx == 5'd12 && tx_valid) && n < 100) begin @(negedge clk); n++; end
    check("rst_idx12_seen", 32'(byte_idx), 32'd12);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_stays_idle", 32'(busy), 32'd0);
    pulse_start();
    check("rf_sel_cycle1", 32'(sel_out), 32'd1);
    wait_done(3, 200);
    check_frame("rf");
    check("rf_first_valid", 32'(first_valid_rel), 32'd3);
    check("rf_done_cycle", 32'(done_rel), DONE_REL);

`ifdef TDC_RDOUT_CHKSUM_EN
    // Checksum frame: 0xA5 ^ 0x3C = 0x99.
    dmode = 1'b1;
    pulse_start();
    wait_done(4, 200);
    check("ck_count", 32'(rx_q.size()), 32'd25);
    if (rx_q.size() == 25) begin
      check("ck_byte5", 32'(rx_q[5]), 32'h3C);
      check("ck_byte23", 32'(rx_q[23]), 32'hA5);
      check("ck_chksum", 32'(rx_q[24]), 32'h99);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_readout_seq.md
# tdc_readout_seq

Readout sequencer for the TDC status/result frame. It drives the 24-bit one-hot byte select consumed by the select decoder: bit 0 selects the FPGA ID byte, 5:1 the version bytes, 6 the priority-encoder byte, 22:7 the sixteen counter bytes, and 23 the DAC byte. For each selected byte it samples the shared 8-bit readout bus and streams the byte to the host transmit path over a valid/ready handshake. It sits between the host command decoder, which issues `start`, and the byte-wide TX FIFO/UART.

## Interface
- `NSEL`, 24: number of frame bytes, which is also the select width; must be at least 2.
- `SETTLE`, 2: cycles each select is held before the bus is sampled; must be at least 1.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: frame request; sampled only in IDLE.
- `data_in` in 8: readout bus; holds the byte addressed by `sel_out`.
- `sel_out` out NSEL: one-hot byte select to the decoder input.
- `tx_data` out 8: byte to the host path.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts; a transfer occurs on a cycle where `tx_valid` and `tx_ready` are both 1.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse at end of frame.
- `byte_idx` out 5: index of the current byte, 0..NSEL-1.

## Operation
**States:** IDLE, SELECT, SEND, CHK (present only with the macro defined), DONE.

**IDLE**
- `start`=1 → SELECT, with `byte_idx` set to 0 and the settle counter cleared.

**SELECT**
- `sel_out` = 1 << `byte_idx`; the settle counter increments each cycle.
- On the SETTLE-th cycle: `tx_data` ← `data_in`, then → SEND.

**SEND**
- `tx_valid` = 1 and `sel_out` = 0.
- `tx_data` is held stable until the transfer occurs.
- On transfer with `byte_idx` < NSEL-1: `byte_idx` increments, then → SELECT.
- On transfer with `byte_idx` = NSEL-1: → CHK if the macro is defined, else → DONE.

**DONE**
- `frame_done` = 1 for one cycle, then → IDLE.

**Output rules**
- `busy` = 1 in every state except IDLE.
- `sel_out` is either all-zero or exactly one bit set; never multi-hot.
- `start` outside IDLE is ignored; no queuing.
- `byte_idx` does not wrap inside a frame.
- `byte_idx` holds its last value in DONE and IDLE, and is cleared on the next accepted `start`.

**Reset**
- `rst` at any time, including mid-frame or mid-backpressure: next cycle state=IDLE, `sel_out`=0, `tx_valid`=0, `tx_data`=0x00, `busy`=0, `frame_done`=0, `byte_idx`=0, settle counter=0, checksum=0x00.
- A partially sent frame is abandoned; there is no resume.

## Timing
- All outputs are registered.
- `start` accepted at cycle 0 → `sel_out` bit 0 is high in cycles 1..SETTLE → first `tx_valid` in cycle SETTLE+1.
- With `tx_ready` held at 1, each byte costs SETTLE+1 cycles.
- Frame cost with `tx_ready` held at 1: NSEL·(SETTLE+1) cycles, plus 1 for CHK if enabled, plus 1 DONE cycle.
- `tx_ready` low stretches SEND indefinitely; `sel_out` stays 0 and `byte_idx` is unchanged.
- `tx_ready` high outside SEND/CHK has no effect.
- Earliest next frame: a `start` held high is accepted in the IDLE cycle after DONE.

## Configuration
- Macro: `TDC_RDOUT_CHKSUM_EN`.
- **Defined:**
  - An 8-bit running XOR of all NSEL transferred bytes is kept; it is cleared at `start` acceptance.
  - CHK state: `tx_valid`=1, `tx_data`=XOR value, `sel_out`=0, `byte_idx`=NSEL-1.
  - On transfer → DONE. The frame is NSEL+1 bytes.
- **Undefined:** no checksum logic; the frame is exactly NSEL bytes.

## Test plan
- SETTLE=2, `tx_ready`=1, `data_in`=0x10+`byte_idx`, pulse `start` → 24 bytes 0x10..0x27 in order; first `tx_valid` at cycle 3; `frame_done` at cycle 73 without the macro, cycle 74 with it.
- Every cycle of the frame → `sel_out` is 0 or one-hot; bit k is high only while `byte_idx`=k in SELECT; no select during SEND.
- Drop `tx_ready` for 5 cycles while byte 7 is in SEND → `tx_valid` and `tx_data` held, `byte_idx`=7, `sel_out`=0; resumes with byte 8 after the transfer; byte count still 24.
- Pulse `start` at byte 10 → ignored: no restart and still a single `frame_done`.
- Assert `rst` during SEND of byte 12 → next cycle all outputs are at reset values; a new `start` → the frame begins again at byte 0.
- Macro defined, `data_in`=0x00 except 0xA5 when `byte_idx`=23, plus 0x3C when `byte_idx`=5 → 25th byte = 0x99.
